inst_loader: RTL and testbench



---
 rtl/inst_loader.sv | 173 +++++++++++++++++
 tb/tb_inst_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
//  Module      : inst_loader
//  Description : Framed byte-stream program loader for a 32-word instruction
//                memory. Assembles little-endian words, strobes each into
//                memory, verifies an XOR checksum and releases core reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [8:0] C_DEPTH = 9'(DEPTH);

    state_t              r_state;
    state_t              w_next_state;
    logic                w_in_frame;
    logic                w_accept;
    logic                w_count_bad;
    logic                w_last_word;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W-1:0]   r_word_idx;
    logic [1:0]          r_byte_idx;
    logic [23:0]         r_asm;
    logic [7:0]          r_checksum;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic                r_core_rst;
    logic                r_done;
    logic                r_error;

    // The loader is receptive to bytes only while a frame is open.
    assign w_in_frame  = (r_state == S_COUNT) || (r_state == S_DATA) || (r_state == S_CHECK);
    assign w_accept    = byte_valid && w_in_frame;
    assign w_count_bad = (byte_data == 8'd0) || ({1'b0, byte_data} > C_DEPTH);
    // Word index stops at N-1, so comparing against the latched count never wraps.
    assign w_last_word = ({1'b0, r_word_idx} == (r_count - {{ADDR_W{1'b0}}, 1'b1}));

    assign byte_ready = w_in_frame;
    assign busy       = w_in_frame;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign core_rst   = r_core_rst;
    assign done       = r_done;
    assign error      = r_error;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; start is only honoured outside an open frame.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_next_state = S_COUNT;
            end
            S_COUNT: begin
                if (w_accept) w_next_state = w_count_bad ? S_ERR : S_DATA;
            end
            S_DATA: begin
                if (w_accept && (r_byte_idx == 2'd3) && w_last_word) w_next_state = S_CHECK;
            end
            S_CHECK: begin
                if (w_accept) w_next_state = (byte_data == r_checksum) ? S_DONE : S_ERR;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: word assembly, checksum, write strobe and result flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count     <= '0;
            r_word_idx  <= '0;
            r_byte_idx  <= 2'd0;
            r_asm       <= 24'd0;
            r_checksum  <= 8'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
            r_core_rst  <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_core_rst <= 1'b0;
                    end
                end
                S_COUNT: begin
                    if (w_accept) begin
                        if (w_count_bad) begin
                            r_error    <= 1'b1;
                            r_core_rst <= 1'b0;
                        end else begin
                            r_count    <= byte_data[ADDR_W:0];
                            r_word_idx <= '0;
                            r_byte_idx <= 2'd0;
                            r_checksum <= byte_data;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_checksum <= r_checksum ^ byte_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_asm[7:0]   <= byte_data;
                            2'd1: r_asm[15:8]  <= byte_data;
                            2'd2: r_asm[23:16] <= byte_data;
                            default: begin
                                r_mem_wdata <= {byte_data, r_asm};
                                r_mem_addr  <= r_word_idx;
                                r_mem_we    <= 1'b1;
                                if (!w_last_word) r_word_idx <= r_word_idx + {{(ADDR_W-1){1'b0}}, 1'b1};
                            end
                        endcase
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        if (byte_data == r_checksum) begin
                            r_done     <= 1'b1;
                            r_core_rst <= 1'b1;
                        end else begin
                            r_error    <= 1'b1;
                            r_core_rst <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_loader
//  Description : Self-checking bench for inst_loader. Expected memory writes
//                are queued as stimulus is driven and compared on each strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_loader;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'd0;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              error;

    int checks = 0;
    int fails  = 0;

    logic [ADDR_W+31:0] exp_q[$];
    logic [7:0]         frame_q[$];
    logic [ADDR_W+31:0] mon_exp;

    inst_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Scoreboard: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr %0d data %h, no write expected", mem_addr, mem_wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== mon_exp) begin
                    fails++;
                    $display("FAIL write_match: got addr %0d data %h, expected addr %0d data %h",
                             mem_addr, mem_wdata, mon_exp[ADDR_W+31:32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) begin
            checks++;
            fails++;
            $display("FAIL byte_timeout: byte %h not accepted, byte_ready %b expected 1", b, byte_ready);
        end else begin
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({byte_ready, busy, done, error, core_rst} !== 5'b11000) begin
            fails++;
            $display("FAIL start_entry: ready/busy/done/error/core_rst = %b expected 11000",
                     {byte_ready, busy, done, error, core_rst});
        end
    endtask

    // Sends frame_q with an independent model of word assembly and checksum.
    task automatic send_frame(input int stall, input bit pulse_start);
        int          n;
        bit          cnt_ok;
        logic [7:0]  x;
        logic [31:0] w;
        int          last;
        n      = int'(frame_q[0]);
        cnt_ok = (n != 0) && (n <= DEPTH);
        x      = 8'd0;
        w      = 32'd0;
        last   = frame_q.size() - 1;
        for (int i = 0; i <= last; i++) begin
            if (cnt_ok && i >= 1 && i <= 4 * n) begin
                w[8 * ((i - 1) % 4) +: 8] = frame_q[i];
                if ((i - 1) % 4 == 3) exp_q.push_back({ADDR_W'((i - 1) / 4), w});
            end
            if (i < last) x ^= frame_q[i];
            send_byte(frame_q[i]);
            if (cnt_ok && i >= 1 && i <= 4 * n && (i - 1) % 4 == 3) begin
                checks++;
                if (mem_we !== 1'b1) begin
                    fails++;
                    $display("FAIL we_timing: mem_we %b after byte %0d, expected 1", mem_we, i);
                end
            end
            if (i < last) begin
                for (int s = 0; s < stall; s++) begin
                    start = (pulse_start && i == 3 && s == 0);
                    @(posedge clk); #1;
                end
                start = 1'b0;
            end
        end
        checks++;
        if (cnt_ok && x == frame_q[last]) begin
            if ({done, error, core_rst, busy, byte_ready} !== 5'b10100) begin
                fails++;
                $display("FAIL result_done: done/error/core_rst/busy/ready = %b expected 10100",
                         {done, error, core_rst, busy, byte_ready});
            end
        end else begin
            if ({done, error, core_rst, busy, byte_ready} !== 5'b01000) begin
                fails++;
                $display("FAIL result_error: done/error/core_rst/busy/ready = %b expected 01000",
                         {done, error, core_rst, busy, byte_ready});
            end
        end
        @(posedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL writes_missing: %0d writes outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({byte_ready, mem_we, mem_addr, mem_wdata, core_rst, busy, done, error} !== '0) begin
            fails++;
            $display("FAIL reset_values: ready %b we %b addr %0d data %h core_rst %b busy %b done %b error %b, expected all 0",
                     byte_ready, mem_we, mem_addr, mem_wdata, core_rst, busy, done, error);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (byte_ready !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_quiet: ready %b busy %b expected 0 0", byte_ready, busy);
        end
    endtask

    task automatic test_single_word();
        do_start();
        frame_q = '{8'h01, 8'h93, 8'h60, 8'hA1, 8'h00, 8'h53};
        send_frame(0, 1'b0);
    endtask

    task automatic test_two_words();
        do_start();
        frame_q = '{8'h02, 8'h13, 8'h01, 8'h50, 8'h00, 8'h33, 8'h02, 8'h21, 8'h00, 8'h50};
        send_frame(0, 1'b0);
    endtask

    task automatic test_bad_check();
        do_start();
        frame_q = '{8'h01, 8'h93, 8'h60, 8'hA1, 8'h00, 8'h52};
        send_frame(0, 1'b0);
    endtask

    task automatic test_bad_count();
        do_start();
        frame_q = '{8'h00};
        send_frame(0, 1'b0);
        do_start();
        frame_q = '{8'h21};
        send_frame(0, 1'b0);
        // Largest legal count still accepted: check the loader is in DATA.
        do_start();
        send_byte(8'h20);
        checks++;
        if ({byte_ready, busy, error} !== 3'b110) begin
            fails++;
            $display("FAIL count_max: ready/busy/error = %b expected 110", {byte_ready, busy, error});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_stalled();
        do_start();
        frame_q = '{8'h02, 8'h13, 8'h01, 8'h50, 8'h00, 8'h33, 8'h02, 8'h21, 8'h00, 8'h50};
        send_frame(3, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        do_start();
        send_byte(8'h02);
        exp_q.push_back({ADDR_W'(0), 32'h00500113});
        send_byte(8'h13);
        send_byte(8'h01);
        send_byte(8'h50);
        send_byte(8'h00);
        send_byte(8'h33);
        send_byte(8'h02);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({byte_ready, mem_we, mem_addr, mem_wdata, core_rst, busy, done, error} !== '0) begin
            fails++;
            $display("FAIL midframe_reset: ready %b we %b addr %0d data %h core_rst %b busy %b done %b error %b, expected all 0",
                     byte_ready, mem_we, mem_addr, mem_wdata, core_rst, busy, done, error);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL midframe_writes: %0d outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        do_start();
        frame_q = '{8'h01, 8'h93, 8'h60, 8'hA1, 8'h00, 8'h53};
        send_frame(0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single_word();
        test_two_words();
        test_bad_check();
        test_bad_count();
        test_stalled();
        test_reset_mid_frame();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
